cn_seq_driver: RTL
==================

CN_SEQ_DRIVER -- requirements
Module: cn_seq_driver

Interface
REQ-001 SHALL have parameter LEN_W, default 4, the width of the command run-length field.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, a synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid, input, 1, command offered.
REQ-005 SHALL have port cmd_ready, output, 1, command accepted when cmd_valid and cmd_ready are both 1 at a rising clk edge.
REQ-006 SHALL have port cmd_op, input, 2, operation: 0=HOLD, 1=SET, 2=CLEAR, 3=TOGGLE.
REQ-007 SHALL have port cmd_len, input, LEN_W, run length; the operation is applied for cmd_len+1 cycles.
REQ-008 SHALL have port q_fb, input, 1, q fed back from the downstream CN flip-flop.
REQ-009 SHALL have port c, output, 1, the change-enable to the CN flip-flop.
REQ-010 SHALL have port n, output, 1, the next-value to the CN flip-flop.
REQ-011 SHALL have port busy, output, 1, high while in RUN.
REQ-012 SHALL have port done, output, 1, a one-cycle pulse on the final cycle of a run.
REQ-013 SHALL have port err, output, 1, a sticky mismatch flag, present only when CN_DRV_CHECK_EN is defined.

Function
REQ-014 SHALL drive a CN flip-flop with these semantics: c=1 loads n into q at the edge; c=0 holds q.
REQ-015 SHALL implement the states IDLE and RUN.
REQ-016 IDLE SHALL drive cmd_ready=1, c=0, n=0, busy=0.
REQ-017 On accept in IDLE, the block SHALL latch op, load the counter with cmd_len, and enter RUN on the next cycle.
REQ-018 RUN SHALL drive the ops as follows:
- HOLD: c=0, n=0.
- SET: c=1, n=1.
- CLEAR: c=1, n=0.
- TOGGLE: c=1, n=~q_fb (combinational).
REQ-019 In RUN, the counter SHALL decrement each cycle; the cycle with counter==0 SHALL be the final cycle.
REQ-020 On the final cycle, the block SHALL drive done=1 and cmd_ready=1; cmd_ready SHALL be 0 on every other RUN cycle.
REQ-021 An accept on the final cycle SHALL start the next command on the following cycle, staying in RUN with no idle gap.
REQ-022 With no accept on the final cycle, the block SHALL return to IDLE.
REQ-023 cmd_len=0 SHALL give exactly one RUN cycle, with done asserted in that same cycle.
REQ-024 cmd_len at all-ones SHALL give 2^LEN_W RUN cycles; the counter SHALL NOT wrap.
REQ-025 cmd_op, cmd_len and cmd_valid SHALL be ignored while cmd_ready=0.

Reset
REQ-026 While rst=1 at an edge, the block SHALL go to IDLE with counter=0, c=0, n=0, busy=0, done=0, cmd_ready=1, err=0.
REQ-027 rst SHALL take priority over an accept in the same cycle; that command SHALL be dropped.
REQ-028 rst mid-run SHALL abort the run without a done pulse; c=0 SHALL hold from the next cycle.

Configuration
REQ-029 When CN_DRV_CHECK_EN is defined, a shadow register qexp SHALL load n at each edge where c=1.
REQ-030 When CN_DRV_CHECK_EN is defined, a valid flag SHALL set on the first such edge.
REQ-031 When CN_DRV_CHECK_EN is defined and the valid flag is set, q_fb!=qexp SHALL set err, which SHALL stay 1 until rst.
REQ-032 When CN_DRV_CHECK_EN is undefined, there SHALL be no err port and no shadow logic; all other behaviour SHALL be identical.

Verification
REQ-033 SHALL cover: reset, then SET with len=2 -> c=1,n=1 for 3 cycles, done on the 3rd, then IDLE with c=0.
REQ-034 SHALL cover: CLEAR len=0 followed back-to-back by SET len=1 on the done cycle -> RUN cycles c/n = 1/0, 1/1, 1/1 with no gap; done pulses twice.
REQ-035 SHALL cover: TOGGLE len=3 with a cn_ff attached, q starting at 0 -> q sequence 1,0,1,0; n always equals ~q.
REQ-036 SHALL cover: HOLD len=15 -> busy for 16 cycles with c=0 and q unchanged; cmd_valid pulses during RUN are not accepted.
REQ-037 SHALL cover: rst asserted on the 2nd cycle of SET len=5 -> IDLE next cycle, no done, cmd_ready=1.
REQ-038 SHALL cover, with CN_DRV_CHECK_EN defined: q_fb forced to 0 during SET -> err=1 one cycle after the first loading edge, held until rst.

Source files
------------

// File: rtl/cn_seq_driver.sv
// Run-length command sequencer that drives the c/n inputs of a downstream CN flip-flop.
// Optional shadow checking of q_fb is enabled by defining CN_DRV_CHECK_EN (adds the err port).
module cn_seq_driver #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             q_fb,
    output logic             c,
    output logic             n,
    output logic             busy,
    output logic             done
`ifdef CN_DRV_CHECK_EN
    ,
    output logic             err
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'd0,
        OP_SET    = 2'd1,
        OP_CLEAR  = 2'd2,
        OP_TOGGLE = 2'd3
    } op_e;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_HOLD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        cmd_ready = 1'b0;
        c         = 1'b0;
        n         = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_d = RUN;
                    op_d    = op_e'(cmd_op);
                    cnt_d   = cmd_len;
                end
            end
            RUN: begin
                busy = 1'b1;
                case (op_q)
                    OP_SET:    begin c = 1'b1; n = 1'b1;  end
                    OP_CLEAR:  begin c = 1'b1; n = 1'b0;  end
                    OP_TOGGLE: begin c = 1'b1; n = ~q_fb; end
                    default:   begin c = 1'b0; n = 1'b0;  end
                endcase
                // Final cycle: a command accepted here chains straight into the next run.
                if (cnt_q == '0) begin
                    done      = 1'b1;
                    cmd_ready = 1'b1;
                    if (cmd_valid) begin
                        op_d  = op_e'(cmd_op);
                        cnt_d = cmd_len;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef CN_DRV_CHECK_EN
    logic qexp_q, qexp_d;
    logic qvalid_q, qvalid_d;
    logic err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            qexp_q   <= 1'b0;
            qvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            qexp_q   <= qexp_d;
            qvalid_q <= qvalid_d;
            err_q    <= err_d;
        end
    end

    // Shadow copy of the downstream flop; mismatch is only meaningful once it has been loaded.
    always_comb begin
        qexp_d   = qexp_q;
        qvalid_d = qvalid_q;
        err_d    = err_q;
        if (qvalid_q && (q_fb != qexp_q)) begin
            err_d = 1'b1;
        end
        if (c) begin
            qexp_d   = n;
            qvalid_d = 1'b1;
        end
    end

    assign err = err_q;
`endif

endmodule
